// File: rtl/io_port_device_if.sv
// io_port_device_if: device-side rx/tx byte streams.
// slave = port block, master = attached device.
interface io_port_device_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/io_port_device.sv
// io_port_device: CPU byte port bridging a shared IO bus to rx/tx FIFOs.
// IO_PORT_DEVICE_STATUS_EN adds a stat input for status reads and flag clears.
module io_port_device #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sel,
  input  logic      io_read,
  input  logic      io_write,
  inout  wire [7:0] IO,
`ifdef IO_PORT_DEVICE_STATUS_EN
  input  logic      stat,
`endif
  io_port_device_if.slave dev,
  output logic      ovf,
  output logic      udf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   rx_cnt, tx_cnt;
  logic          live;

  logic st;
`ifdef IO_PORT_DEVICE_STATUS_EN
  assign st = stat;
`else
  assign st = 1'b0;
`endif

  logic rd_cyc, wr_cyc;
  logic rx_full, tx_full, tx_empty;
  logic rx_push, rx_pop, tx_push, tx_pop;

  assign rd_cyc   = sel & io_read & ~io_write;
  assign wr_cyc   = sel & io_write;
  assign rx_full  = (rx_cnt == FULL);
  assign tx_full  = (tx_cnt == FULL);
  assign tx_empty = (tx_cnt == '0);

  assign dev.rx_valid = (rx_cnt != '0);
  assign dev.rx_data  = dev.rx_valid ? rx_mem[rx_rp] : 8'h00;
  // live holds tx_ready low until the first edge after reset
  assign dev.tx_ready = live & ~tx_full;

  assign rx_push = wr_cyc & ~st & ~rx_full;
  assign rx_pop  = dev.rx_valid & dev.rx_ready;
  assign tx_push = dev.tx_valid & dev.tx_ready;
  assign tx_pop  = rd_cyc & ~st & ~tx_empty;

  logic [7:0] head, io_val;
  assign head = tx_empty ? 8'h00 : tx_mem[tx_rp];
`ifdef IO_PORT_DEVICE_STATUS_EN
  assign io_val = st ?
    {4'b0, ovf, udf, ~tx_empty, rx_full} : head;
`else
  assign io_val = head;
`endif
  assign IO = rd_cyc ? io_val : 8'hzz;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= IO;
    if (tx_push) tx_mem[tx_wp] <= dev.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      rx_cnt <= '0;
      tx_cnt <= '0;
      live   <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      live <= 1'b1;
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push)
                - (AW+1)'(rx_pop);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push)
                - (AW+1)'(tx_pop);
      if (wr_cyc && !st && rx_full)  ovf <= 1'b1;
      if (rd_cyc && !st && tx_empty) udf <= 1'b1;
`ifdef IO_PORT_DEVICE_STATUS_EN
      if (wr_cyc && st && IO[3]) ovf <= 1'b0;
      if (wr_cyc && st && IO[2]) udf <= 1'b0;
`endif
    end
  end
endmodule
